// File: rtl/shift_streamer_arbiter_if.sv
// shift_streamer_arbiter_if: bundles the two producer channels, the streamer-side channel and status.
// Ports (signals): data0/shift0/last0/vld0/rdy0 - req0 (BPC coder) packet channel
//                  data1/shift1/last1/vld1/rdy1 - req1 (ZRLE coder) packet channel
//                  data/shift/vld/rdy           - streamer data_i/shift_i/vld_i and its rdy_o
//                  flush_req/flush/idle/done    - end-of-stream flush handshake
//                  grant/busy                   - arbitration status
// Modports: master = producers + streamer side, slave = arbiter side.
interface shift_streamer_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int SW = $clog2(DATA_W + 1)
);
   logic [2*DATA_W-1:0] data0, data1, data;
   logic [SW-1:0] shift0, shift1, shift;
   logic last0, last1, vld0, vld1, rdy0, rdy1;
   logic flush_req, vld, rdy, flush, idle, busy, done;
   logic [1:0] grant;
   modport master (
      output data0, shift0, last0, vld0, data1, shift1, last1, vld1, flush_req, rdy, idle,
      input rdy0, rdy1, data, shift, vld, flush, grant, busy, done
   );
   modport slave (
      input data0, shift0, last0, vld0, data1, shift1, last1, vld1, flush_req, rdy, idle,
      output rdy0, rdy1, data, shift, vld, flush, grant, busy, done
   );
endinterface

// File: rtl/shift_streamer_arbiter.sv
// shift_streamer_arbiter: shares one shift_streamer between req0 (BPC) and req1 (ZRLE) producers,
// granting bursts of up to MAX_BURST beats, and sequences the end-of-stream flush.
// Ports: clk - clock; rst - synchronous active-high reset;
//        bus - shift_streamer_arbiter_if.slave (producer channels in, streamer channel out,
//              flush_req/idle in, flush/done/grant/busy out).
// Config: define SS_ARB_FIXED_PRIO_EN to make req0 always win contention (req1 can starve);
//         default is round-robin.
package ebpc_pkg;
   localparam int DATA_W = 8;
endpackage

module shift_streamer_arbiter
   import ebpc_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input logic clk,
   input logic rst,
   shift_streamer_arbiter_if.slave bus
);
   localparam int SW = $clog2(DATA_W + 1);
   localparam int CW = $clog2(MAX_BURST + 1);
   typedef enum logic [1:0] {ARB, BUSY, FLUSH, DONE} state_t;
   state_t state;
   logic [1:0] gnt;
   logic [CW-1:0] beat_cnt;
   logic rr_ptr, rr_vld, flush_pend;
   logic sel1, live, beat, last, pick1;
   always_comb begin
      sel1 = gnt[1];
      live = !rst && state == BUSY;
      beat = state == BUSY && (sel1 ? bus.vld1 : bus.vld0) && bus.rdy;
      last = sel1 ? bus.last1 : bus.last0;
`ifdef SS_ARB_FIXED_PRIO_EN
      pick1 = bus.vld1 && !bus.vld0;
`else
      // rr_vld stays low until the first burst ends, so req0 wins the first contention after reset
      pick1 = bus.vld1 && (!bus.vld0 || (rr_vld && !rr_ptr));
`endif
   end
   // Outputs are forced low while rst is high so nothing leaks to the streamer during reset
   assign bus.data = live ? (sel1 ? bus.data1 : bus.data0) : '0;
   assign bus.shift = live ? (sel1 ? bus.shift1 : bus.shift0) : '0;
   assign bus.vld = live && (sel1 ? bus.vld1 : bus.vld0);
   assign bus.rdy0 = live && !sel1 && bus.rdy;
   assign bus.rdy1 = live && sel1 && bus.rdy;
   assign bus.grant = rst ? 2'b00 : gnt;
   assign bus.flush = !rst && state == FLUSH;
   assign bus.done = !rst && state == DONE;
   assign bus.busy = !rst && !(state == ARB && !flush_pend);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB;
         gnt <= 2'b00;
         beat_cnt <= '0;
         rr_ptr <= 1'b0;
         rr_vld <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         // ARB with a pending flush always moves to FLUSH, which is where the pending bit is consumed
         flush_pend <= bus.flush_req || (flush_pend && state != ARB);
         case (state)
            ARB:
               if (flush_pend) state <= FLUSH;
               else if (bus.vld0 || bus.vld1) begin
                  state <= BUSY;
                  gnt <= pick1 ? 2'b10 : 2'b01;
               end
            BUSY:
               if (beat) begin
                  if (last || beat_cnt == CW'(MAX_BURST - 1)) begin
                     state <= ARB;
                     gnt <= 2'b00;
                     beat_cnt <= '0;
                     rr_ptr <= sel1;
                     rr_vld <= 1'b1;
                  end else beat_cnt <= beat_cnt + 1'b1;
               end
            FLUSH: state <= bus.idle ? DONE : FLUSH;
            DONE: state <= ARB;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && bus.vld0) assert (bus.shift0 <= SW'(DATA_W)) else $warning("shift0 exceeds DATA_W");
      if (!rst && bus.vld1) assert (bus.shift1 <= SW'(DATA_W)) else $warning("shift1 exceeds DATA_W");
   end
endmodule

// File: tb/tb_shift_streamer_arbiter.sv
// tb_shift_streamer_arbiter: directed reset/flush steps plus randomized packet streams checked
// against a burst-level arbitration plan computed in the bench.
module tb_shift_streamer_arbiter;
   import ebpc_pkg::*;
   localparam int MB = 8;
   localparam int DW = DATA_W;
   localparam int PW = 2 * DW;
   localparam int SW = $clog2(DW + 1);
`ifdef SS_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   typedef struct {
      logic [PW-1:0] data;
      logic [SW-1:0] shift;
      logic last;
   } pkt_t;
   typedef struct {
      int p;
      int idx;
      bit fin;
   } plan_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   pkt_t pa[2][64];
   int n[2];
   int h[2];
   always #5 clk = ~clk;
   shift_streamer_arbiter_if #(.DATA_W(DW)) bus ();
   shift_streamer_arbiter #(.MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic zero(input string tag);
      check(tag, {bus.grant, bus.vld, bus.rdy0, bus.rdy1, bus.flush, bus.busy, bus.done, bus.data, bus.shift}, 0);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_in();
      bus.vld0 = 0; bus.vld1 = 0; bus.last0 = 0; bus.last1 = 0;
      bus.data0 = '0; bus.data1 = '0; bus.shift0 = '0; bus.shift1 = '0;
      bus.flush_req = 0; bus.rdy = 0; bus.idle = 0;
   endtask
   task automatic do_reset();
      rst = 1;
      clear_in();
      tick();
      tick();
      rst = 0;
   endtask
   task automatic run_stream(input int c0, input int c1, input int pct, input int lastp);
      plan_t plan[$];
      plan_t e;
      int ix[2];
      int lastg, k, cyc, p;
      bit first, arb_ph;
      logic [1:0] eg, gotb;
      n[0] = c0; n[1] = c1; h[0] = 0; h[1] = 0;
      for (int q = 0; q < 2; q++)
         for (int i = 0; i < n[q]; i++) begin
            pa[q][i].data = PW'($urandom);
            pa[q][i].shift = SW'($urandom_range(0, DW));
            pa[q][i].last = (lastp > 0 && $urandom_range(1, 100) <= lastp) || i == n[q] - 1;
         end
      ix[0] = 0; ix[1] = 0; first = 1; lastg = 0;
      while (ix[0] < c0 || ix[1] < c1) begin
         if (ix[0] < c0 && ix[1] < c1) p = (FIXED || first) ? 0 : 1 - lastg;
         else p = ix[0] < c0 ? 0 : 1;
         for (int b = 0; b < MB; b++) begin
            e.p = p;
            e.idx = ix[p];
            e.fin = pa[p][ix[p]].last || b == MB - 1;
            plan.push_back(e);
            ix[p]++;
            if (e.fin) break;
         end
         lastg = p;
         first = 0;
      end
      k = 0; cyc = 0; arb_ph = 1;
      while (k < plan.size() && cyc < 3000) begin
         bus.vld0 = h[0] < n[0];
         bus.vld1 = h[1] < n[1];
         bus.data0 = pa[0][h[0]].data; bus.shift0 = pa[0][h[0]].shift; bus.last0 = pa[0][h[0]].last;
         bus.data1 = pa[1][h[1]].data; bus.shift1 = pa[1][h[1]].shift; bus.last1 = pa[1][h[1]].last;
         bus.rdy = $urandom_range(1, 100) <= pct;
         #1;
         e = plan[k];
         eg = e.p == 1 ? 2'b10 : 2'b01;
         gotb = {bus.vld1 & bus.rdy1, bus.vld0 & bus.rdy0};
         if (arb_ph) begin
            check("arb_bubble", {bus.grant, bus.vld, gotb}, 0);
            arb_ph = 0;
         end else begin
            check("grant", bus.grant, eg);
            check("handshake", gotb, bus.rdy ? eg : 2'b00);
            check("payload", {bus.vld, bus.data, bus.shift}, {1'b1, pa[e.p][e.idx].data, pa[e.p][e.idx].shift});
            if (bus.rdy) begin
               arb_ph = e.fin;
               k++;
            end
         end
         tick();
         if (gotb[0]) h[0]++;
         if (gotb[1]) h[1]++;
         cyc++;
      end
      check("stream_done", k, plan.size());
      clear_in();
   endtask
   initial begin
      clear_in();
      bus.vld0 = 1; bus.vld1 = 1; bus.rdy = 1;
      bus.data0 = PW'($urandom); bus.data1 = PW'($urandom); bus.shift0 = 5; bus.shift1 = 7;
      tick(); #1 zero("reset_hold");
      tick(); rst = 0; #1 zero("post_reset");
      tick(); #1 check("first_grant", bus.grant, 2'b01);
      repeat (7) tick();
      #1 check("burst_len", {bus.grant, bus.vld}, 3'b011);
      tick(); #1 check("bubble", {bus.grant, bus.vld}, 0);
      tick(); #1 check("rr_grant", bus.grant, FIXED ? 2'b01 : 2'b10);
      repeat (5) tick();
      #1 check("pre_reset", bus.grant, FIXED ? 2'b01 : 2'b10);
      rst = 1;
      #1 zero("reset_during");
      tick(); rst = 0; #1 zero("reset_after");
      tick(); #1 check("reset_pref", bus.grant, 2'b01);
      do_reset(); run_stream(24, 24, 100, 0);
      do_reset(); run_stream(12, 12, 100, 20);
      do_reset(); run_stream(20, 6, 60, 15);
      do_reset(); run_stream(0, 10, 50, 25);
      do_reset(); run_stream(16, 16, 35, 10);
      do_reset();
      bus.vld0 = 1; bus.rdy = 1;
      #1 check("fm_arb", bus.grant, 0);
      for (int b = 1; b <= 4; b++) begin
         tick();
         bus.flush_req = b == 2;
         bus.last0 = b == 4;
         bus.data0 = PW'($urandom);
         #1 check("fm_beat", {bus.grant, bus.vld, bus.flush, bus.data}, {2'b01, 1'b1, 1'b0, bus.data0});
      end
      tick();
      clear_in();
      #1 check("fm_arb2", {bus.grant, bus.vld, bus.flush, bus.busy}, 4'b0001);
      repeat ($urandom_range(2, 5)) begin
         tick();
         bus.vld1 = 1; bus.rdy = 1;
         #1 check("fm_hold", {bus.flush, bus.vld, bus.rdy1, bus.done}, 4'b1000);
      end
      tick(); bus.vld1 = 0; bus.idle = 1;
      #1 check("fm_idle", {bus.flush, bus.done}, 2'b10);
      tick(); bus.idle = 0;
      #1 check("fm_done", {bus.flush, bus.done}, 2'b01);
      tick(); #1 check("fm_end", {bus.flush, bus.done, bus.busy}, 0);
      do_reset();
      bus.idle = 1; bus.flush_req = 1;
      #1 check("fi_arb", bus.busy, 0);
      tick(); bus.flush_req = 0;
      #1 check("fi_pend", {bus.flush, bus.busy, bus.done}, 3'b010);
      tick(); bus.flush_req = 1;
      #1 check("fi_flush", {bus.flush, bus.done}, 2'b10);
      tick(); bus.flush_req = 0;
      #1 check("fi_done", {bus.flush, bus.done}, 2'b01);
      tick(); #1 check("fi_again", {bus.flush, bus.done, bus.busy}, 3'b001);
      tick(); #1 check("fi_flush2", {bus.flush, bus.done}, 2'b10);
      tick(); #1 check("fi_done2", {bus.flush, bus.done}, 2'b01);
      tick(); #1 check("fi_end", {bus.flush, bus.done, bus.busy}, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
